wts_ram_arbiter: RTL and testbench
==================================

WTS_RAM_ARBITER -- requirements
Module: wts_ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for ramack (range 2..255).
REQ-002 SHALL have parameter IDLE_DATA, default 8'hFF, meaning the read data returned on timeout.
REQ-003 clk  in  1  system clock (21.47727MHz); one clock domain only.
REQ-004 nreset  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-006 cpu_wrt  in  1  CPU write (1) / read (0), stable while cpu_req=1.
REQ-007 cpu_adr  in  21  CPU RAM address.
REQ-008 cpu_dbo  in  8  CPU write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-010 cpu_dbi  out  8  CPU read data, valid while cpu_ack=1.
REQ-011 snd_req  in  1  sound-engine sample-fetch request (read only), level.
REQ-012 snd_adr  in  21  sample address.
REQ-013 snd_ack  out  1  one-cycle completion pulse to the sound engine.
REQ-014 snd_q  out  8  sample data, valid while snd_ack=1.
REQ-015 ramreq  out  1  RAM request, level, held until ramack or timeout.
REQ-016 ramwrt  out  1  RAM write strobe qualifier.
REQ-017 ramadr  out  21  RAM address.
REQ-018 ramdbo  out  8  RAM write data.
REQ-019 ramdbi  in  8  RAM read data, valid with ramack.
REQ-020 ramack  in  1  one-cycle RAM completion pulse.
REQ-021 timeout_err  out  1  one-cycle pulse when an access times out.

Function
REQ-022 SHALL implement FSM states IDLE, CPU, SND, DONE.
REQ-023 IDLE: if only one request is pending, SHALL go to that requester's state next cycle.
REQ-024 IDLE, both requests pending: SHALL grant the requester not granted last; last_grant resets to CPU, so SND wins the first tie.
REQ-025 On entry to CPU/SND, SHALL register ramreq=1 and drive ramadr/ramwrt/ramdbo from the granted port (snd: ramwrt=0, ramdbo=0), all held stable until exit.
REQ-026 ramack seen at cycle k in CPU/SND: at k+1 SHALL pulse the granted ack, present ramdbi (latched at k) on dbi/q, drop ramreq and enter DONE.
REQ-027 DONE SHALL last exactly one cycle, then return to IDLE; requests are not sampled in DONE (requester drops req after ack).
REQ-028 Minimum service time: req at t -> ramreq at t+1 -> ack at t+2 with ramack at t+1.
REQ-029 The wait counter SHALL clear on grant and increment each CPU/SND cycle without ramack; at count TIMEOUT SHALL drop ramreq, pulse ack with data IDLE_DATA, pulse timeout_err, and enter DONE.
REQ-030 ramack in IDLE or DONE SHALL be ignored.
REQ-031 ramack and timeout in the same cycle: ramack SHALL win (normal completion, no timeout_err).
REQ-032 cpu_dbi/snd_q SHALL hold the last delivered value between acks.
REQ-033 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-034 nreset=0 SHALL asynchronously force state IDLE, last_grant=CPU, counter=0, and all outputs to 0, including mid-access (the pending access is abandoned, no ack).

Structure
REQ-035 State encoding, TIMEOUT and IDLE_DATA defaults SHALL live in shared package wts_pkg.
REQ-036 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-037 cpu_req write adr=21'h01234 dbo=8'h5A, ramack 3 cycles later -> ramadr=21'h01234, ramwrt=1, ramdbo=8'h5A, one cpu_ack pulse, no snd_ack.
REQ-038 cpu_req and snd_req raised in the same cycle after reset -> SND served first, then CPU; repeat with both -> order alternates.
REQ-039 snd_req read, ramack never -> ramreq high for exactly 15 cycles, snd_ack with snd_q=8'hFF, timeout_err pulse.
REQ-040 ramack arrives on cycle 15 -> normal snd_ack with ramdbi value, no timeout_err.
REQ-041 nreset pulsed low while in CPU with ramreq=1 -> all outputs 0 immediately, no cpu_ack, next request served normally.
REQ-042 Back-to-back cpu_req with ramack held high -> ack every 4 cycles, single ramreq per access.

Source files
------------

// File: rtl/wts_pkg.sv
// wts_pkg: shared state encoding and defaults for the wavetable sound RAM arbiter.
package wts_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_SND, ST_DONE} state_t;
  localparam int WTS_TIMEOUT = 15;
  localparam logic [7:0] WTS_IDLE_DATA = 8'hFF;
endpackage

// File: rtl/wts_ram_arbiter.sv
// wts_ram_arbiter: arbitrates CPU and sound-engine accesses onto one RAM port with ack timeout.
module wts_ram_arbiter
  import wts_pkg::*;
#(
  parameter int TIMEOUT = WTS_TIMEOUT,
  parameter logic [7:0] IDLE_DATA = WTS_IDLE_DATA
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cpu_req,
  input  logic        cpu_wrt,
  input  logic [20:0] cpu_adr,
  input  logic [7:0]  cpu_dbo,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dbi,
  input  logic        snd_req,
  input  logic [20:0] snd_adr,
  output logic        snd_ack,
  output logic [7:0]  snd_q,
  output logic        ramreq,
  output logic        ramwrt,
  output logic [20:0] ramadr,
  output logic [7:0]  ramdbo,
  input  logic [7:0]  ramdbi,
  input  logic        ramack,
  output logic        timeout_err
);
  state_t      state, state_n;
  logic        last_snd, last_snd_n;
  logic [7:0]  cnt, cnt_n;
  logic        cpu_ack_n, snd_ack_n, ramreq_n, ramwrt_n, tmo_n, grant_snd, done;
  logic [7:0]  cpu_dbi_n, snd_q_n, ramdbo_n, rd_data;
  logic [20:0] ramadr_n;
  // on a tie the sound engine wins unless it was the last one served
  assign grant_snd = snd_req & (~cpu_req | ~last_snd);
  // ramack beats a timeout landing in the same cycle
  assign done      = ramack | (cnt == 8'(TIMEOUT - 1));
  assign rd_data   = ramack ? ramdbi : IDLE_DATA;
  always_comb begin
    state_n    = state;
    last_snd_n = last_snd;
    cnt_n      = cnt;
    ramreq_n   = ramreq;
    ramwrt_n   = ramwrt;
    ramadr_n   = ramadr;
    ramdbo_n   = ramdbo;
    cpu_dbi_n  = cpu_dbi;
    snd_q_n    = snd_q;
    cpu_ack_n  = 1'b0;
    snd_ack_n  = 1'b0;
    tmo_n      = 1'b0;
    unique case (state)
      ST_IDLE: if (cpu_req | snd_req) begin
        state_n    = grant_snd ? ST_SND : ST_CPU;
        last_snd_n = grant_snd;
        cnt_n      = 8'd0;
        ramreq_n   = 1'b1;
        ramwrt_n   = grant_snd ? 1'b0 : cpu_wrt;
        ramadr_n   = grant_snd ? snd_adr : cpu_adr;
        ramdbo_n   = grant_snd ? 8'h00 : cpu_dbo;
      end
      ST_CPU, ST_SND: if (done) begin
        state_n   = ST_DONE;
        ramreq_n  = 1'b0;
        tmo_n     = ~ramack;
        cpu_ack_n = state == ST_CPU;
        snd_ack_n = state == ST_SND;
        cpu_dbi_n = state == ST_CPU ? rd_data : cpu_dbi;
        snd_q_n   = state == ST_SND ? rd_data : snd_q;
      end else begin
        cnt_n = cnt + 8'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      last_snd    <= 1'b0;
      cnt         <= 8'd0;
      ramreq      <= 1'b0;
      ramwrt      <= 1'b0;
      ramadr      <= 21'd0;
      ramdbo      <= 8'd0;
      cpu_ack     <= 1'b0;
      cpu_dbi     <= 8'd0;
      snd_ack     <= 1'b0;
      snd_q       <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      last_snd    <= last_snd_n;
      cnt         <= cnt_n;
      ramreq      <= ramreq_n;
      ramwrt      <= ramwrt_n;
      ramadr      <= ramadr_n;
      ramdbo      <= ramdbo_n;
      cpu_ack     <= cpu_ack_n;
      cpu_dbi     <= cpu_dbi_n;
      snd_ack     <= snd_ack_n;
      snd_q       <= snd_q_n;
      timeout_err <= tmo_n;
    end
  end
endmodule

// File: tb/tb_wts_ram_arbiter.sv
// tb_wts_ram_arbiter: directed scenario tests for wts_ram_arbiter with hand-computed expectations.
module tb_wts_ram_arbiter;
  logic        clk = 1'b0, nreset = 1'b0;
  logic        cpu_req = 1'b0, cpu_wrt = 1'b0, snd_req = 1'b0, ramack = 1'b0;
  logic [20:0] cpu_adr = '0, snd_adr = '0;
  logic [7:0]  cpu_dbo = '0, ramdbi = '0;
  logic        cpu_ack, snd_ack, ramreq, ramwrt, timeout_err;
  logic [7:0]  cpu_dbi, snd_q, ramdbo;
  logic [20:0] ramadr;
  int vec = 0, errs = 0;

  wts_ram_arbiter dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_wrt(cpu_wrt), .cpu_adr(cpu_adr), .cpu_dbo(cpu_dbo),
    .cpu_ack(cpu_ack), .cpu_dbi(cpu_dbi),
    .snd_req(snd_req), .snd_adr(snd_adr), .snd_ack(snd_ack), .snd_q(snd_q),
    .ramreq(ramreq), .ramwrt(ramwrt), .ramadr(ramadr), .ramdbo(ramdbo),
    .ramdbi(ramdbi), .ramack(ramack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    tick(2);
    vec++; if ({ramreq, ramwrt, cpu_ack, snd_ack, timeout_err} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b want 00000", {ramreq, ramwrt, cpu_ack, snd_ack, timeout_err}); end
    vec++; if ({ramadr, ramdbo, cpu_dbi, snd_q} !== 45'b0) begin errs++; $display("FAIL reset_buses got %h want 0", {ramadr, ramdbo, cpu_dbi, snd_q}); end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_tie;
    cpu_req = 1'b1; cpu_wrt = 1'b0; cpu_adr = 21'h0AAAA;
    snd_req = 1'b1; snd_adr = 21'h15555;
    ramack = 1'b1; ramdbi = 8'h11;
    tick();
    vec++; if (ramreq !== 1'b1 || ramadr !== 21'h15555 || ramwrt !== 1'b0) begin errs++; $display("FAIL tie1_first_snd got req=%b adr=%h wrt=%b want 1 15555 0", ramreq, ramadr, ramwrt); end
    tick();
    vec++; if (snd_ack !== 1'b1 || cpu_ack !== 1'b0 || snd_q !== 8'h11) begin errs++; $display("FAIL tie1_snd_ack got sack=%b cack=%b q=%h want 1 0 11", snd_ack, cpu_ack, snd_q); end
    snd_req = 1'b0; ramdbi = 8'h22;
    tick(2);
    vec++; if (ramreq !== 1'b1 || ramadr !== 21'h0AAAA) begin errs++; $display("FAIL tie1_then_cpu got req=%b adr=%h want 1 0aaaa", ramreq, ramadr); end
    tick();
    vec++; if (cpu_ack !== 1'b1 || cpu_dbi !== 8'h22 || snd_q !== 8'h11) begin errs++; $display("FAIL tie1_cpu_ack got ack=%b dbi=%h q=%h want 1 22 11", cpu_ack, cpu_dbi, snd_q); end
    cpu_req = 1'b0;
    tick();
    snd_req = 1'b1; ramdbi = 8'h33;
    tick(2);
    snd_req = 1'b0;
    tick();
    cpu_req = 1'b1; snd_req = 1'b1;
    tick();
    vec++; if (ramadr !== 21'h0AAAA) begin errs++; $display("FAIL tie2_first_cpu got adr=%h want 0aaaa", ramadr); end
    tick();
    vec++; if (cpu_ack !== 1'b1 || snd_ack !== 1'b0) begin errs++; $display("FAIL tie2_cpu_ack got cack=%b sack=%b want 1 0", cpu_ack, snd_ack); end
    cpu_req = 1'b0;
    tick(2);
    vec++; if (ramadr !== 21'h15555 || ramreq !== 1'b1) begin errs++; $display("FAIL tie2_then_snd got adr=%h req=%b want 15555 1", ramadr, ramreq); end
    tick();
    vec++; if (snd_ack !== 1'b1) begin errs++; $display("FAIL tie2_snd_ack got %b want 1", snd_ack); end
    snd_req = 1'b0; ramack = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write;
    cpu_req = 1'b1; cpu_wrt = 1'b1; cpu_adr = 21'h01234; cpu_dbo = 8'h5A; ramdbi = 8'h44;
    tick();
    vec++; if (ramreq !== 1'b1 || ramadr !== 21'h01234 || ramwrt !== 1'b1 || ramdbo !== 8'h5A) begin errs++; $display("FAIL wr_drive got req=%b adr=%h wrt=%b dbo=%h want 1 01234 1 5a", ramreq, ramadr, ramwrt, ramdbo); end
    tick(2);
    ramack = 1'b1;
    vec++; if (ramreq !== 1'b1 || cpu_ack !== 1'b0 || ramdbo !== 8'h5A) begin errs++; $display("FAIL wr_hold got req=%b ack=%b dbo=%h want 1 0 5a", ramreq, cpu_ack, ramdbo); end
    tick();
    ramack = 1'b0;
    vec++; if (cpu_ack !== 1'b1 || snd_ack !== 1'b0 || ramreq !== 1'b0 || timeout_err !== 1'b0) begin errs++; $display("FAIL wr_ack got cack=%b sack=%b req=%b tmo=%b want 1 0 0 0", cpu_ack, snd_ack, ramreq, timeout_err); end
    cpu_req = 1'b0; cpu_wrt = 1'b0;
    tick();
    vec++; if (cpu_ack !== 1'b0 || cpu_dbi !== 8'h44) begin errs++; $display("FAIL wr_pulse got ack=%b dbi=%h want 0 44", cpu_ack, cpu_dbi); end
    tick();
  endtask

  task automatic test_timeout;
    int n = 0, k = 0;
    snd_req = 1'b1; snd_adr = 21'h00777;
    while (k < 40 && snd_ack !== 1'b1) begin
      tick();
      k++;
      if (ramreq === 1'b1) n++;
    end
    vec++; if (snd_ack !== 1'b1) begin errs++; $display("FAIL tmo_no_ack got snd_ack=%b after %0d cycles want 1", snd_ack, k); end
    vec++; if (n !== 15) begin errs++; $display("FAIL tmo_req_len got %0d want 15", n); end
    vec++; if (snd_q !== 8'hFF || timeout_err !== 1'b1 || cpu_ack !== 1'b0) begin errs++; $display("FAIL tmo_ack got q=%h tmo=%b cack=%b want ff 1 0", snd_q, timeout_err, cpu_ack); end
    snd_req = 1'b0;
    tick();
    vec++; if (timeout_err !== 1'b0 || snd_ack !== 1'b0) begin errs++; $display("FAIL tmo_pulse got tmo=%b ack=%b want 0 0", timeout_err, snd_ack); end
    tick();
  endtask

  task automatic test_late_ack;
    snd_req = 1'b1; ramdbi = 8'hC3;
    tick(15);
    ramack = 1'b1;
    vec++; if (ramreq !== 1'b1) begin errs++; $display("FAIL late_req15 got %b want 1", ramreq); end
    tick();
    ramack = 1'b0;
    vec++; if (snd_ack !== 1'b1 || snd_q !== 8'hC3 || timeout_err !== 1'b0) begin errs++; $display("FAIL late_ack got ack=%b q=%h tmo=%b want 1 c3 0", snd_ack, snd_q, timeout_err); end
    vec++; if (cpu_dbi !== 8'h44) begin errs++; $display("FAIL late_cpu_hold got %h want 44", cpu_dbi); end
    snd_req = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    cpu_req = 1'b1; cpu_wrt = 1'b1; cpu_adr = 21'h1F00F; cpu_dbo = 8'hA5;
    tick(2);
    vec++; if (ramreq !== 1'b1) begin errs++; $display("FAIL mid_pre got ramreq=%b want 1", ramreq); end
    nreset = 1'b0;
    #1;
    vec++; if ({ramreq, ramwrt, ramadr, ramdbo, cpu_dbi, snd_q} !== 47'b0) begin errs++; $display("FAIL mid_async got %h want 0", {ramreq, ramwrt, ramadr, ramdbo, cpu_dbi, snd_q}); end
    cpu_req = 1'b0; cpu_wrt = 1'b0;
    @(posedge clk);
    #1 nreset = 1'b1;
    repeat (3) begin
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    vec++; if (acks !== 0) begin errs++; $display("FAIL mid_no_ack got %0d acks want 0", acks); end
    cpu_req = 1'b1; cpu_adr = 21'h00042; ramack = 1'b1; ramdbi = 8'h77;
    tick();
    vec++; if (ramreq !== 1'b1 || ramadr !== 21'h00042) begin errs++; $display("FAIL mid_after_req got req=%b adr=%h want 1 00042", ramreq, ramadr); end
    tick();
    vec++; if (cpu_ack !== 1'b1 || cpu_dbi !== 8'h77) begin errs++; $display("FAIL mid_after_ack got ack=%b dbi=%h want 1 77", cpu_ack, cpu_dbi); end
    cpu_req = 1'b0; ramack = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back;
    int ack_at[$];
    int nreq = 0;
    logic last_ack = 1'b0;
    ramack = 1'b1; cpu_req = 1'b1; cpu_adr = 21'h00100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ramreq === 1'b1) nreq++;
      if (cpu_ack === 1'b1) ack_at.push_back(c);
      cpu_req = ~last_ack;
      last_ack = cpu_ack;
    end
    cpu_req = 1'b0; ramack = 1'b0;
    vec++; if (ack_at.size() !== 5) begin errs++; $display("FAIL b2b_count got %0d acks want 5", ack_at.size()); end
    vec++; if (nreq !== ack_at.size()) begin errs++; $display("FAIL b2b_ramreq got %0d req cycles want %0d", nreq, ack_at.size()); end
    for (int i = 1; i < ack_at.size(); i++) begin
      vec++; if (ack_at[i] - ack_at[i-1] !== 4) begin errs++; $display("FAIL b2b_gap%0d got %0d want 4", i, ack_at[i] - ack_at[i-1]); end
    end
    tick(3);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_cpu_write();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
